// File: rtl/rom_load_pkg.sv
// Shared types and helpers for the ROM download / core reset sequencer.
// Holds the FSM state encoding and the ROM address range check.
package rom_load_pkg;

    // Width of the HPS ioctl byte address.
    localparam int IOCTL_AW = 25;

    // Encoding is visible on state_o, so it is fixed explicitly.
    typedef enum logic [1:0] {
        HOLD = 2'd0,
        RUN  = 2'd1,
        LOAD = 2'd2,
        POST = 2'd3
    } ctrl_state_t;

    // True when a byte address falls inside the ROM image.
    function automatic logic addr_in_range(
        input logic [IOCTL_AW-1:0] addr,
        input int unsigned         rom_bytes
    );
        return 32'(addr) < rom_bytes;
    endfunction

endpackage

// File: rtl/rom_load_reset_ctrl_if.sv
// ioctl download stream in, filtered ROM write port out.
// master: HPS side (drives ioctl_*), slave: sequencer (drives dn_*).
interface rom_load_reset_ctrl_if #(
    parameter int ADDR_W = 17
);
    import rom_load_pkg::*;

    logic                ioctl_download;
    logic                ioctl_wr;
    logic [IOCTL_AW-1:0] ioctl_addr;
    logic [7:0]          ioctl_data;

    logic [ADDR_W-1:0]   dn_addr;
    logic [7:0]          dn_data;
    logic                dn_wr;

    modport master (
        output ioctl_download,
        output ioctl_wr,
        output ioctl_addr,
        output ioctl_data,
        input  dn_addr,
        input  dn_data,
        input  dn_wr
    );

    modport slave (
        input  ioctl_download,
        input  ioctl_wr,
        input  ioctl_addr,
        input  ioctl_data,
        output dn_addr,
        output dn_data,
        output dn_wr
    );

endinterface

// File: rtl/hold_timer.sv
// Loadable down-counter timing the reset hold after reset/download.
// Ports: clk_sys, Reset_I, load (reload), dec (count), expire flag.
module hold_timer #(
    parameter int CNT_W       = 16,
    parameter int HOLD_CYCLES = 1024
) (
    input  logic clk_sys,
    input  logic Reset_I,
    input  logic load,
    input  logic dec,
    output logic expire
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk_sys or negedge Reset_I) begin
        if (!Reset_I) begin
            cnt <= RELOAD;
        end else if (load) begin
            cnt <= RELOAD;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Set when this decrement lands on zero (or it already sits there),
    // so the FSM can leave on the same edge the count hits zero.
    assign expire = (cnt <= CNT_W'(1));

endmodule

// File: rtl/rom_load_reset_ctrl.sv
// ROM download filter and core reset sequencer for the arcade core.
// Ports: clk_sys, Reset_I, rst_req, dl (ioctl in / dn out),
//        core_reset_n, rom_valid, load_err, state_o.
module rom_load_reset_ctrl
    import rom_load_pkg::*;
#(
    parameter int ADDR_W      = 17,
    parameter int ROM_BYTES   = 16384,
    parameter int HOLD_CYCLES = 1024,
    parameter int CNT_W       = 16
) (
    input  logic                        clk_sys,
    input  logic                        Reset_I,
    input  logic                        rst_req,
    rom_load_reset_ctrl_if.slave        dl,
    output logic                        core_reset_n,
    output logic                        rom_valid,
    output logic                        load_err,
    output logic [1:0]                  state_o
);

    localparam logic [CNT_W-1:0] ROM_CNT = CNT_W'(ROM_BYTES);

    ctrl_state_t      state;
    logic [CNT_W-1:0] byte_cnt;
    logic             ovf;

    logic             in_rng;
    logic             wr_ok;
    logic [CNT_W-1:0] cnt_nx;
    logic             ovf_nx;
    logic             img_ok;

    logic             tmr_load;
    logic             tmr_dec;
    logic             tmr_expire;

    assign in_rng = addr_in_range(dl.ioctl_addr, ROM_BYTES);
    assign wr_ok  = dl.ioctl_wr && in_rng;

    // Byte count / overflow including the current strobe, so a write in
    // the cycle download falls still counts toward the image.
    always_comb begin
        cnt_nx = byte_cnt;
        ovf_nx = ovf;
        if (wr_ok && byte_cnt != ROM_CNT) begin
            cnt_nx = byte_cnt + 1'b1;
        end
        if (dl.ioctl_wr && !in_rng) begin
            ovf_nx = 1'b1;
        end
    end

    assign img_ok = (cnt_nx == ROM_CNT) && !ovf_nx;

    always_comb begin
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        unique case (state)
            HOLD, POST: begin
                if (!dl.ioctl_download) begin
                    tmr_load = rst_req;
                    tmr_dec  = !rst_req;
                end
            end
            RUN: begin
                tmr_load = !dl.ioctl_download && rst_req;
            end
            LOAD: begin
                tmr_load = !dl.ioctl_download;
            end
        endcase
    end

    hold_timer #(
        .CNT_W       (CNT_W),
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold_timer (
        .clk_sys (clk_sys),
        .Reset_I (Reset_I),
        .load    (tmr_load),
        .dec     (tmr_dec),
        .expire  (tmr_expire)
    );

    always_ff @(posedge clk_sys or negedge Reset_I) begin
        if (!Reset_I) begin
            state        <= HOLD;
            byte_cnt     <= '0;
            ovf          <= 1'b0;
            dl.dn_wr     <= 1'b0;
            dl.dn_addr   <= '0;
            dl.dn_data   <= '0;
            core_reset_n <= 1'b0;
            rom_valid    <= 1'b0;
            load_err     <= 1'b0;
        end else begin
            dl.dn_wr <= 1'b0;
            unique case (state)
                HOLD, POST: begin
                    if (dl.ioctl_download) begin
                        state        <= LOAD;
                        byte_cnt     <= '0;
                        ovf          <= 1'b0;
                        rom_valid    <= 1'b0;
                        load_err     <= 1'b0;
                        core_reset_n <= 1'b0;
                    end else if (!rst_req && tmr_expire) begin
                        // No valid image: park in HOLD with the timer at 0.
                        state        <= rom_valid ? RUN : HOLD;
                        core_reset_n <= rom_valid;
                    end
                end
                RUN: begin
                    if (dl.ioctl_download) begin
                        state        <= LOAD;
                        byte_cnt     <= '0;
                        ovf          <= 1'b0;
                        rom_valid    <= 1'b0;
                        load_err     <= 1'b0;
                        core_reset_n <= 1'b0;
                    end else if (rst_req) begin
                        state        <= HOLD;
                        core_reset_n <= 1'b0;
                    end
                end
                LOAD: begin
                    if (wr_ok) begin
                        dl.dn_wr   <= 1'b1;
                        dl.dn_addr <= dl.ioctl_addr[ADDR_W-1:0];
                        dl.dn_data <= dl.ioctl_data;
                    end
                    byte_cnt <= cnt_nx;
                    ovf      <= ovf_nx;
                    if (!dl.ioctl_download) begin
                        state     <= POST;
                        rom_valid <= img_ok;
                        load_err  <= !img_ok;
                    end
                end
            endcase
        end
    end

    assign state_o = state;

endmodule

// File: doc/rom_load_reset_ctrl.md
Name: rom_load_reset_ctrl

Overview:
Sequences ROM download and core reset for the arcade core. Filters the HPS ioctl byte stream into a bounded ROM write port (dn_addr/dn_data/dn_wr) for the game core. Merges all reset sources into one core reset. Holds the core in reset during a download and for a fixed settle period afterwards. Keeps the core in reset until one complete, in-range ROM image has loaded.

Parameters:
ADDR_W, 17, width of dn_addr.
ROM_BYTES, 16384, required image size; valid addresses are 0..ROM_BYTES-1.
HOLD_CYCLES, 1024, clk_sys cycles the core stays in reset after any reset or download end; must be >= 1.
CNT_W, 16, width of hold counter and byte counter; must satisfy 2^CNT_W > max(ROM_BYTES, HOLD_CYCLES).

Ports:
clk_sys  in  1  system clock; single clock domain.
Reset_I  in  1  asynchronous, active-low reset.
rst_req  in  1  synchronous reset request, level (RESET | status[0] | buttons[1]).
ioctl_download  in  1  download active, level.
ioctl_wr  in  1  one-cycle byte strobe.
ioctl_addr  in  25  byte address.
ioctl_data  in  8  byte data.
dn_addr  out  ADDR_W  registered ROM write address.
dn_data  out  8  registered ROM write data.
dn_wr  out  1  registered one-cycle ROM write strobe.
core_reset_n  out  1  active-low reset to the game core.
rom_valid  out  1  last download was complete and in range.
load_err  out  1  last download had an out-of-range byte or was short.
state_o  out  2  current FSM state, for debug.

Behaviour:
- Asynchronous reset (Reset_I=0):
  - State goes to HOLD and hold_cnt=HOLD_CYCLES.
  - byte_cnt=0, dn_wr=0, dn_addr=0, dn_data=0.
  - core_reset_n=0, rom_valid=0, load_err=0.
- FSM states: HOLD=0, RUN=1, LOAD=2, POST=3. All outputs are registered.
- HOLD:
  - core_reset_n=0 and hold_cnt decrements each cycle.
  - ioctl_download=1 has priority: go to LOAD, byte_cnt=0, rom_valid=0, load_err=0.
  - Otherwise, when hold_cnt reaches 0: go to RUN if rom_valid=1; stay in HOLD with hold_cnt=0 if rom_valid=0.
  - rst_req=1 reloads hold_cnt=HOLD_CYCLES.
- RUN:
  - core_reset_n=1.
  - ioctl_download=1: go to LOAD (same init as above), with priority over rst_req.
  - rst_req=1: go to HOLD, hold_cnt=HOLD_CYCLES.
  - core_reset_n goes low on the cycle after the triggering input is sampled.
- LOAD:
  - core_reset_n=0.
  - Each ioctl_wr with ioctl_addr < ROM_BYTES produces, next cycle: dn_wr=1, dn_addr=ioctl_addr[ADDR_W-1:0], dn_data=ioctl_data. byte_cnt increments, saturating at ROM_BYTES.
  - Each ioctl_wr with ioctl_addr >= ROM_BYTES: dn_wr stays 0 and a sticky overflow flag is set.
  - ioctl_download falling: go to POST with hold_cnt=HOLD_CYCLES. A write strobe in that same cycle is still forwarded.
  - rom_valid is set at that transition only if byte_cnt==ROM_BYTES and no overflow; otherwise load_err=1.
  - byte_cnt counts strobes, not unique addresses; duplicate addresses count.
  - rst_req is ignored in LOAD.
- POST:
  - core_reset_n=0 and hold_cnt decrements.
  - At 0: go to RUN if rom_valid, else HOLD with hold_cnt=0.
  - ioctl_download=1 re-enters LOAD.
  - rst_req=1 reloads hold_cnt.
- dn_wr never asserts outside LOAD or the cycle after leaving LOAD. Latency from ioctl_wr to dn_wr is exactly 1 cycle.
- Reset_I mid-download: the image is invalidated (rom_valid=0) and a new download is required.

Decomposition:
- Package rom_load_pkg: state enum (HOLD/RUN/LOAD/POST, 2-bit) and a function that checks the in-range address against ROM_BYTES.
- One sub-module, hold_timer: loadable down-counter with load/zero flag, reused for HOLD and POST.

Test Plan:
- Reset, no download -> core_reset_n=0 indefinitely; state_o=0; dn_wr never 1.
- Download of 16384 bytes, addr 0..16383, one strobe every 4 cycles -> dn_wr exactly 16384 times, each 1 cycle after ioctl_wr, with matching addr/data. After download falls: rom_valid=1, load_err=0. core_reset_n rises exactly 1024 cycles later.
- Download with one write at addr 0x4000 plus the full image -> no dn_wr for 0x4000; load_err=1, rom_valid=0; core stays in reset.
- Short download of 100 bytes -> load_err=1, rom_valid=0; core_reset_n stays 0.
- In RUN, 1-cycle rst_req pulse -> core_reset_n=0 next cycle and back to 1 after 1024 cycles. A second rst_req at cycle 500 extends the total to 1524 cycles.
- In RUN, ioctl_download and rst_req rise together -> LOAD entered; rom_valid cleared; a wr in the final download cycle is forwarded. Reset_I pulse mid-load -> all outputs return to reset values.
